// File: rtl/half_adder_unit.sv
// rtl/half_adder_unit.sv - registered lane-parallel half adder with carry statistics
module half_adder_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [WIDTH-1:0]             i_bit1,
  input  logic [WIDTH-1:0]             i_bit2,
  input  logic                         i_clear,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_sum,
  output logic [WIDTH-1:0]             o_carry,
  output logic                         o_carry_any,
  output logic [$clog2(WIDTH+1)-1:0]   o_carry_count,
  output logic [CNT_W-1:0]             o_event_count
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;
  logic             carry_any_next;
  logic [CW-1:0]    carry_count_next;
  logic             event_hit;
  logic             event_sat;

  // Per-lane sum/carry and the statistics derived from the same new carries
  always_comb begin
    sum_next         = i_bit1 ^ i_bit2;
    carry_next       = i_bit1 & i_bit2;
    carry_any_next   = |carry_next;
    carry_count_next = '0;
    for (int k = 0; k < WIDTH; k++) begin
      carry_count_next = carry_count_next + CW'(carry_next[k]);
    end
  end

  // Event qualification: an accepted cycle with at least one carrying lane,
  // suppressed once the counter has reached its ceiling
  always_comb begin
    event_hit = i_valid && carry_any_next;
    event_sat = &o_event_count;
  end

  // Result registers: load on valid, hold otherwise; o_valid tracks i_valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_sum         <= '0;
      o_carry       <= '0;
      o_carry_any   <= 1'b0;
      o_carry_count <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_sum         <= sum_next;
        o_carry       <= carry_next;
        o_carry_any   <= carry_any_next;
        o_carry_count <= carry_count_next;
      end
    end
  end

  // Saturating carry-event counter; clear wins over a same-cycle event
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_event_count <= '0;
    end else if (i_clear) begin
      o_event_count <= '0;
    end else if (event_hit && !event_sat) begin
      o_event_count <= o_event_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_half_adder_unit.sv
// tb/tb_half_adder_unit.sv - directed and randomized checks of half_adder_unit
module tb_half_adder_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // WIDTH=1, CNT_W=2 instance
  logic       v1 = 0, c1 = 0;
  logic [0:0] a1 = 0, b1 = 0;
  logic       ov1, oany1;
  logic [0:0] osum1, ocar1, ocnt1;
  logic [1:0] oev1;

  // WIDTH=4, CNT_W=16 instance
  logic        v4 = 0, c4 = 0;
  logic [3:0]  a4 = 0, b4 = 0;
  logic        ov4, oany4;
  logic [3:0]  osum4, ocar4;
  logic [2:0]  ocnt4;
  logic [15:0] oev4;

  // WIDTH=8, CNT_W=4 instance
  logic       v8 = 0, c8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       ov8, oany8;
  logic [7:0] osum8, ocar8;
  logic [3:0] ocnt8;
  logic [3:0] oev8;

  half_adder_unit #(.WIDTH(1), .CNT_W(2)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_bit1(a1), .i_bit2(b1), .i_clear(c1),
    .o_valid(ov1), .o_sum(osum1), .o_carry(ocar1), .o_carry_any(oany1),
    .o_carry_count(ocnt1), .o_event_count(oev1));

  half_adder_unit #(.WIDTH(4), .CNT_W(16)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_bit1(a4), .i_bit2(b4), .i_clear(c4),
    .o_valid(ov4), .o_sum(osum4), .o_carry(ocar4), .o_carry_any(oany4),
    .o_carry_count(ocnt4), .o_event_count(oev4));

  half_adder_unit #(.WIDTH(8), .CNT_W(4)) u_d8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .i_bit1(a8), .i_bit2(b8), .i_clear(c8),
    .o_valid(ov8), .o_sum(osum8), .o_carry(ocar8), .o_carry_any(oany8),
    .o_carry_count(ocnt8), .o_event_count(oev8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [1:0] s, input logic [1:0] c,
                      input logic v, input logic [1:0] ev);
    chk({tag, "_sum"}, 32'(osum1), 32'(s));
    chk({tag, "_carry"}, 32'(ocar1), 32'(c));
    chk({tag, "_valid"}, 32'(ov1), 32'(v));
    chk({tag, "_any"}, 32'(oany1), 32'(c));
    chk({tag, "_cnt"}, 32'(ocnt1), 32'(c));
    chk({tag, "_ev"}, 32'(oev1), 32'(ev));
  endtask

  logic [7:0] m_sum, m_car;
  logic       m_v;
  logic [3:0] m_ev;

  initial begin
    // Reset state
    rst = 1; tick();
    chk1("reset", 0, 0, 0, 0);
    chk("reset_d4_valid", 32'(ov4), 0);
    chk("reset_d4_ev", 32'(oev4), 0);
    chk("reset_d8_valid", 32'(ov8), 0);
    rst = 0;

    // WIDTH=1 truth table
    v1 = 1; a1 = 0; b1 = 0; tick(); chk1("tt00", 0, 0, 1, 0);
    a1 = 0; b1 = 1; tick();          chk1("tt01", 1, 0, 1, 0);
    a1 = 1; b1 = 0; tick();          chk1("tt10", 1, 0, 1, 0);
    a1 = 1; b1 = 1; tick();          chk1("tt11", 0, 1, 1, 1);

    // Hold with invalid, changing operands
    v1 = 0;
    a1 = 0; b1 = 1; tick(); chk1("hold0", 0, 1, 0, 1);
    a1 = 1; b1 = 1; tick(); chk1("hold1", 0, 1, 0, 1);
    a1 = 1; b1 = 0; tick(); chk1("hold2", 0, 1, 0, 1);

    // Reset in the middle of a carry-producing stream
    v1 = 1; a1 = 1; b1 = 1; tick(); chk1("pre_rst", 0, 1, 1, 2);
    rst = 1; tick(); chk1("mid_rst", 0, 0, 0, 0);
    rst = 0; tick(); chk1("post_rst", 0, 1, 1, 1);

    // Saturation with CNT_W=2, then clear racing a valid event
    v1 = 0; c1 = 1; tick(); chk1("clr_idle", 0, 1, 0, 0);
    c1 = 0; v1 = 1; a1 = 1; b1 = 1;
    tick(); chk1("sat1", 0, 1, 1, 1);
    tick(); chk1("sat2", 0, 1, 1, 2);
    tick(); chk1("sat3", 0, 1, 1, 3);
    tick(); chk1("sat4", 0, 1, 1, 3);
    tick(); chk1("sat5", 0, 1, 1, 3);
    c1 = 1; tick(); chk1("clr_pri", 0, 1, 1, 0);
    c1 = 0; v1 = 0;

    // WIDTH=4 vectors
    v4 = 1; a4 = 4'b1100; b4 = 4'b1010; tick();
    chk("w4a_sum", 32'(osum4), 32'h6);
    chk("w4a_carry", 32'(ocar4), 32'h8);
    chk("w4a_any", 32'(oany4), 1);
    chk("w4a_cnt", 32'(ocnt4), 1);
    chk("w4a_ev", 32'(oev4), 1);
    a4 = 4'b1111; b4 = 4'b1111; tick();
    chk("w4b_sum", 32'(osum4), 0);
    chk("w4b_carry", 32'(ocar4), 32'hf);
    chk("w4b_cnt", 32'(ocnt4), 4);
    chk("w4b_ev", 32'(oev4), 2);
    a4 = 4'b0101; b4 = 4'b1010; tick();
    chk("w4c_sum", 32'(osum4), 32'hf);
    chk("w4c_any", 32'(oany4), 0);
    chk("w4c_cnt", 32'(ocnt4), 0);
    chk("w4c_ev", 32'(oev4), 2);
    v4 = 0;

    // WIDTH=8 random against a reference model
    m_sum = 0; m_car = 0; m_v = 0; m_ev = 0;
    for (int n = 0; n < 1000; n++) begin
      v8 = 1'($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom_range(0, 15) == 0);
      m_v = v8;
      if (v8) begin
        m_sum = a8 ^ b8;
        m_car = a8 & b8;
      end
      if (c8) m_ev = 0;
      else if (v8 && (a8 & b8) != 0 && m_ev != 4'hf) m_ev = m_ev + 1;
      tick();
      chk("rnd_valid", 32'(ov8), 32'(m_v));
      chk("rnd_sum", 32'(osum8), 32'(m_sum));
      chk("rnd_carry", 32'(ocar8), 32'(m_car));
      chk("rnd_any", 32'(oany8), 32'(m_car != 0));
      chk("rnd_cnt", 32'(ocnt8), 32'($countones(m_car)));
      chk("rnd_ev", 32'(oev8), 32'(m_ev));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder_unit.md
Name: half_adder_unit

Overview:
- Registered, lane-parallel half adder: WIDTH independent 1-bit lanes, each producing sum (XOR) and carry (AND).
- Adds a valid qualifier, per-result carry statistics and a saturating carry-event counter.
- Sits as a leaf arithmetic primitive in datapaths and self-check blocks; WIDTH=1 gives a plain clocked half adder.

Parameters:
- WIDTH, 1, number of independent bit lanes (>=1).
- CNT_W, 16, width of carry-event counter (>=1).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  operands valid this cycle.
- i_bit1  input  WIDTH  operand A, one bit per lane.
- i_bit2  input  WIDTH  operand B, one bit per lane.
- i_clear  input  1  synchronous clear of o_event_count.
- o_valid  output  1  registered results valid.
- o_sum  output  WIDTH  per-lane sum, i_bit1 XOR i_bit2.
- o_carry  output  WIDTH  per-lane carry, i_bit1 AND i_bit2.
- o_carry_any  output  1  OR of all lanes of o_carry.
- o_carry_count  output  $clog2(WIDTH+1)  number of lanes with carry set.
- o_event_count  output  CNT_W  saturating count of accepted cycles with any carry.

Behaviour:
- Clock: single clock i_clk; reset i_rst is synchronous and active-high; no other clocks or async inputs.
- Reset, checked at the edge with i_rst=1: o_valid=0, o_sum=0, o_carry=0, o_carry_any=0, o_carry_count=0, o_event_count=0. Reset overrides i_valid and i_clear.
- Latency is 1 cycle. On an edge with i_valid=1:
  - o_sum[k] <= i_bit1[k] ^ i_bit2[k] and o_carry[k] <= i_bit1[k] & i_bit2[k], for every lane k.
  - o_carry_any and o_carry_count are computed from the same new carries and registered in the same edge, so they stay coherent with o_carry.
  - o_valid <= 1.
- On an edge with i_valid=0:
  - o_valid <= 0.
  - o_sum, o_carry, o_carry_any and o_carry_count hold their previous values.
- Lanes are fully independent; there is no ripple between lanes. sum + 2*carry equals bit1 + bit2 per lane.
- o_carry_count range is 0..WIDTH; its width holds WIDTH exactly (e.g. WIDTH=1 gives 1 bit, WIDTH=4 gives 3 bits).
- o_event_count:
  - Increments by 1 on each edge where i_valid=1 and any input lane has both bits set.
  - Saturates at 2^CNT_W-1 and never wraps.
  - i_clear=1 sets it to 0; clear has priority over a simultaneous increment, and that cycle's event is not counted.
  - i_clear does not affect the result registers or o_valid.
- Input handling: X/undefined inputs are not required to be handled. The inputs carry no back-pressure; every i_valid cycle is accepted.
- Reset asserted mid-stream: the next cycle shows all outputs zero. The first valid after reset deasserts produces o_valid=1 one edge later.

Test Plan:
- WIDTH=1 truth table: apply (0,0),(0,1),(1,0),(1,1) with i_valid=1, one per cycle. Required one cycle later, as sum/carry: 0/0, 1/0, 1/0, 0/1. o_event_count ends at 1.
- WIDTH=4: i_bit1=4'b1100, i_bit2=4'b1010, valid. Required next cycle: o_sum=4'b0110, o_carry=4'b1000, o_carry_any=1, o_carry_count=1. With both inputs 4'b1111: o_sum=0, o_carry=4'b1111, o_carry_count=4.
- Hold: after a valid result, drive i_valid=0 with changing operands for 3 cycles. Required: o_valid=0, o_sum/o_carry unchanged, o_event_count unchanged.
- Reset mid-operation: assert i_rst during a stream of valid carry-producing inputs. Required next edge: all outputs 0. Deassert with one valid (1,1). Required: o_valid=1, o_carry=1, o_event_count=1.
- Saturation/clear with CNT_W=2: 5 consecutive valid (1,1) cycles. Required: count goes 1,2,3,3,3. Then i_clear=1 together with valid (1,1). Required: count=0 and o_carry=1 the same edge.
- Random: 1000 cycles of random i_valid, operands and occasional i_clear, with WIDTH=8. Compare against a reference model each cycle; required zero mismatches.
